// File: rtl/ataque_param_if.sv
// Bundles the button, board and status signals of the attack controller.
// Purely a wiring container with no timing of its own.
// The "slave" modport is the controller side; "master" is the turn FSM / board side.
interface ataque_param_if #(
    parameter int N = 5,
    parameter int W = $clog2(N)
);
    logic               izquierda;
    logic               derecha;
    logic               arriba;
    logic               abajo;
    logic               attack;
    logic               en_attack;
    logic [4*N*N-1:0]   matriz_pc;
    logic [4*N*N-1:0]   matriz_pc_final;
    logic               end_attack;
    logic [2:0]         impact_ship;
    logic [W-1:0]       posicion_x_attack;
    logic [W-1:0]       posicion_y_attack;
    logic               all_sunk;

    modport slave (
        input  izquierda, derecha, arriba, abajo, attack, en_attack, matriz_pc,
        output matriz_pc_final, end_attack, impact_ship,
               posicion_x_attack, posicion_y_attack, all_sunk
    );

    modport master (
        output izquierda, derecha, arriba, abajo, attack, en_attack, matriz_pc,
        input  matriz_pc_final, end_attack, impact_ship,
               posicion_x_attack, posicion_y_attack, all_sunk
    );
endinterface

// File: rtl/ataque_param.sv
// Battleship attack controller: cursor movement, shot resolution, per-ship HP and sunk sweep.
// Latency: move 1 clk; miss/hit end_attack after 2 clks; sinking hit after 2+N*N clks.
// No backpressure: button edges outside IDLE are dropped; end_attack holds until en_attack falls.
module ataque_param #(
    parameter int N         = 5,
    parameter int NUM_SHIPS = 5,
    parameter int WRAP      = 0,
    parameter int W         = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    ataque_param_if.slave bus
);
    localparam int CELLS = N * N;
    localparam int IW    = $clog2(CELLS);
    localparam logic [W-1:0] CTR  = W'(N / 2);
    localparam logic [W-1:0] MAXC = W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESOLVE = 2'd1,
        S_SWEEP   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state, w_next;
    logic [4:0]         r_prev;
    logic [4:0]         w_btn, w_rise;
    logic [W-1:0]       r_x, r_y;
    logic [4*CELLS-1:0] r_board;
    logic [2:0]         r_hp [1:NUM_SHIPS];
    logic [2:0]         r_impact;
    logic               r_end;
    logic [IW-1:0]      r_tgt, r_sweep_idx, w_cur_idx;
    logic [3:0]         r_sink_id, w_ship, w_cur_cell, w_sweep_cell;
    logic               w_accept, w_left, w_right, w_up, w_down, w_fire;
    logic               w_hit, w_sink, w_last, w_all_sunk;

    // Button order {izquierda, derecha, arriba, abajo, attack}; one action per cycle by priority.
    assign w_btn    = {bus.izquierda, bus.derecha, bus.arriba, bus.abajo, bus.attack};
    assign w_rise   = w_btn & ~r_prev;
    assign w_accept = (r_state == S_IDLE) && bus.en_attack;
    assign w_left   = w_accept && w_rise[4];
    assign w_right  = w_accept && w_rise[3] && !w_rise[4];
    assign w_up     = w_accept && w_rise[2] && !(|w_rise[4:3]);
    assign w_down   = w_accept && w_rise[1] && !(|w_rise[4:2]);

    // A fire edge on an already-shot cell is silently ignored.
    assign w_cur_idx  = IW'(r_y) * IW'(N) + IW'(r_x);
    assign w_cur_cell = r_board[{w_cur_idx, 2'b00} +: 4];
    assign w_fire     = w_accept && w_rise[0] && !(|w_rise[4:1]) && (w_cur_cell == 4'd0);

    // Ship ids above NUM_SHIPS are treated as water.
    assign w_ship       = bus.matriz_pc[{r_tgt, 2'b00} +: 4];
    assign w_hit        = (w_ship != 4'd0) && (w_ship <= 4'(NUM_SHIPS));
    assign w_sink       = w_hit && (r_hp[w_ship[2:0]] == 3'd1);
    assign w_sweep_cell = bus.matriz_pc[{r_sweep_idx, 2'b00} +: 4];
    assign w_last       = (r_sweep_idx == IW'(CELLS - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic for the turn sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_fire) w_next = S_RESOLVE;
            S_RESOLVE: w_next = w_sink ? S_SWEEP : S_DONE;
            S_SWEEP:   if (w_last) w_next = S_DONE;
            S_DONE:    if (!bus.en_attack) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Cursor, shot board, HP bookkeeping and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_x         <= CTR;
            r_y         <= CTR;
            r_board     <= '0;
            r_impact    <= '0;
            r_end       <= 1'b0;
            r_tgt       <= '0;
            r_sweep_idx <= '0;
            r_sink_id   <= '0;
            for (int k = 1; k <= NUM_SHIPS; k++) r_hp[k] <= 3'(k);
        end else begin
            r_prev <= w_btn;
            case (r_state)
                S_IDLE: begin
                    if (w_left) begin
                        if (r_x != MAXC)   r_x <= r_x + W'(1);
                        else if (WRAP != 0) r_x <= '0;
                    end else if (w_right) begin
                        if (r_x != '0)      r_x <= r_x - W'(1);
                        else if (WRAP != 0) r_x <= MAXC;
                    end else if (w_up) begin
                        if (r_y != MAXC)    r_y <= r_y + W'(1);
                        else if (WRAP != 0) r_y <= '0;
                    end else if (w_down) begin
                        if (r_y != '0)      r_y <= r_y - W'(1);
                        else if (WRAP != 0) r_y <= MAXC;
                    end
                    if (w_fire) r_tgt <= w_cur_idx;
                end
                S_RESOLVE: begin
                    r_sweep_idx <= '0;
                    r_sink_id   <= w_ship;
                    if (w_hit) begin
                        r_impact <= w_ship[2:0];
                        if (r_hp[w_ship[2:0]] != 3'd0)
                            r_hp[w_ship[2:0]] <= r_hp[w_ship[2:0]] - 3'd1;
                        // A sinking cell is left for the sweep so it only ever reads 8.
                        if (!w_sink) r_board[{r_tgt, 2'b00} +: 4] <= 4'd7;
                    end else begin
                        r_impact <= 3'd0;
                        r_board[{r_tgt, 2'b00} +: 4] <= 4'd6;
                    end
                end
                S_SWEEP: begin
                    if (w_sweep_cell == r_sink_id) r_board[{r_sweep_idx, 2'b00} +: 4] <= 4'd8;
                    if (!w_last) r_sweep_idx <= r_sweep_idx + IW'(1);
                end
                S_DONE: begin
                    if (bus.en_attack) begin
                        r_end <= 1'b1;
                    end else begin
                        r_end <= 1'b0;
                        r_x   <= CTR;
                        r_y   <= CTR;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fleet is sunk once every HP counter reaches zero.
    always_comb begin
        w_all_sunk = 1'b1;
        for (int k = 1; k <= NUM_SHIPS; k++)
            if (r_hp[k] != 3'd0) w_all_sunk = 1'b0;
    end

    assign bus.matriz_pc_final   = r_board;
    assign bus.end_attack        = r_end;
    assign bus.impact_ship       = r_impact;
    assign bus.posicion_x_attack = r_x;
    assign bus.posicion_y_attack = r_y;
    assign bus.all_sunk          = w_all_sunk;
endmodule

// File: tb/tb_ataque_param.sv
// Bench for ataque_param: move-vector table on saturating and wrapping instances,
// then hand-written shot sequences (miss, hit, sink, hold, reshot, invalid id, fleet sunk,
// reset during sweep) checked against a small board/HP model.
module tb_ataque_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ataque_param_if #(.N(5)) bA ();
    ataque_param_if #(.N(5)) bB ();

    assign bB.izquierda = bA.izquierda;
    assign bB.derecha   = bA.derecha;
    assign bB.arriba    = bA.arriba;
    assign bB.abajo     = bA.abajo;
    assign bB.attack    = bA.attack;
    assign bB.en_attack = bA.en_attack;
    assign bB.matriz_pc = bA.matriz_pc;

    ataque_param #(.N(5), .NUM_SHIPS(5), .WRAP(0)) dutA (.clk(clk), .reset(rst), .bus(bA.slave));
    ataque_param #(.N(5), .NUM_SHIPS(5), .WRAP(1)) dutB (.clk(clk), .reset(rst), .bus(bB.slave));

    int checks = 0;
    int errors = 0;
    int map [5][5];
    int mhp [6];
    logic [3:0] mb [25];

    typedef struct {
        logic [4:0] btn;   // {izquierda, derecha, arriba, abajo, attack}
        logic       en;
        int ax, ay, bx, by;
    } mv_t;
    mv_t mv [14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_board(input string nm, input logic [99:0] act, input logic [99:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [99:0] pack_model();
        logic [99:0] v;
        for (int i = 0; i < 25; i++) v[i*4 +: 4] = mb[i];
        return v;
    endfunction

    task automatic set_btn(input logic [4:0] b);
        {bA.izquierda, bA.derecha, bA.arriba, bA.abajo, bA.attack} = b;
    endtask

    task automatic pulse(input logic [4:0] b);
        @(negedge clk) set_btn(b);
        @(negedge clk) set_btn(5'b0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 25; i++) mb[i] = 4'd0;
        for (int k = 1; k <= 5; k++) mhp[k] = k;
    endtask

    task automatic goto(input int y, input int x);
        for (int n = 0; n < 12; n++) begin
            if (int'(bA.posicion_x_attack) < x)      pulse(5'b10000);
            else if (int'(bA.posicion_x_attack) > x) pulse(5'b01000);
            else if (int'(bA.posicion_y_attack) < y) pulse(5'b00100);
            else if (int'(bA.posicion_y_attack) > y) pulse(5'b00010);
        end
        chk("goto_x", int'(bA.posicion_x_attack), x);
        chk("goto_y", int'(bA.posicion_y_attack), y);
    endtask

    // Fire at (y,x), holding attack for 'hold' clocks, and check the resolved turn.
    task automatic shoot(input int y, input int x, input int hold);
        int s, lat, cnt, exp_imp, exp_lat;
        bit hit, sink;
        goto(y, x);
        s    = map[y][x];
        hit  = (s >= 1) && (s <= 5);
        sink = hit && (mhp[s] == 1);
        if (!hit) begin
            mb[y*5+x] = 4'd6;
            exp_imp   = 0;
        end else begin
            mhp[s]--;
            exp_imp = s;
            if (sink) begin
                for (int i = 0; i < 25; i++) if (map[i/5][i%5] == s) mb[i] = 4'd8;
            end else begin
                mb[y*5+x] = 4'd7;
            end
        end
        exp_lat = sink ? 27 : 2;
        lat = -1;
        cnt = 0;
        @(negedge clk) bA.attack = 1'b1;
        while (((lat < 0) || (cnt < hold)) && (cnt < 100)) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= hold) bA.attack = 1'b0;
            if (bA.end_attack && lat < 0) lat = cnt - 1;
        end
        bA.attack = 1'b0;
        chk("shot_latency", lat, exp_lat);
        chk("impact_ship", int'(bA.impact_ship), exp_imp);
        chk_board("board_after_shot", bA.matriz_pc_final, pack_model());
        chk("all_sunk", int'(bA.all_sunk), (mhp[1]+mhp[2]+mhp[3]+mhp[4]+mhp[5]) == 0 ? 1 : 0);
        @(negedge clk) bA.en_attack = 1'b0;
        @(negedge clk);
        chk("end_cleared", int'(bA.end_attack), 0);
        chk("recentre_x", int'(bA.posicion_x_attack), 2);
        chk("recentre_y", int'(bA.posicion_y_attack), 2);
        bA.en_attack = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [99:0] pcv;
        bit reached;
        int row [5];

        // Fleet layout (row y, column x); 6 is an out-of-range ship id that must read as water.
        row = '{5, 5, 5, 5, 5}; for (int x = 0; x < 5; x++) map[0][x] = row[x];
        row = '{2, 2, 0, 0, 1}; for (int x = 0; x < 5; x++) map[1][x] = row[x];
        row = '{6, 0, 0, 0, 0}; for (int x = 0; x < 5; x++) map[2][x] = row[x];
        row = '{3, 3, 3, 0, 0}; for (int x = 0; x < 5; x++) map[3][x] = row[x];
        row = '{4, 4, 4, 4, 0}; for (int x = 0; x < 5; x++) map[4][x] = row[x];
        for (int i = 0; i < 25; i++) pcv[i*4 +: 4] = 4'(map[i/5][i%5]);

        mv[0]  = '{5'b10000, 1'b1, 3, 2, 3, 2};
        mv[1]  = '{5'b10000, 1'b1, 4, 2, 4, 2};
        mv[2]  = '{5'b10000, 1'b1, 4, 2, 0, 2};
        mv[3]  = '{5'b01000, 1'b1, 3, 2, 4, 2};
        mv[4]  = '{5'b00100, 1'b1, 3, 3, 4, 3};
        mv[5]  = '{5'b00100, 1'b1, 3, 4, 4, 4};
        mv[6]  = '{5'b00100, 1'b1, 3, 4, 4, 0};
        mv[7]  = '{5'b00010, 1'b1, 3, 3, 4, 4};
        mv[8]  = '{5'b10000, 1'b0, 3, 3, 4, 4};
        mv[9]  = '{5'b10001, 1'b1, 4, 3, 0, 4};
        mv[10] = '{5'b11000, 1'b1, 4, 3, 1, 4};
        mv[11] = '{5'b01000, 1'b1, 3, 3, 0, 4};
        mv[12] = '{5'b00110, 1'b1, 3, 4, 0, 0};
        mv[13] = '{5'b00010, 1'b1, 3, 3, 0, 4};

        rst = 1'b1;
        bA.en_attack = 1'b0;
        bA.matriz_pc = pcv;
        set_btn(5'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) mb[i] = 4'd0;
        for (int k = 1; k <= 5; k++) mhp[k] = k;
        @(negedge clk);

        chk("reset_x", int'(bA.posicion_x_attack), 2);
        chk("reset_y", int'(bA.posicion_y_attack), 2);
        chk_board("reset_board", bA.matriz_pc_final, '0);
        chk("reset_end", int'(bA.end_attack), 0);
        chk("reset_all_sunk", int'(bA.all_sunk), 0);
        chk("reset_impact", int'(bA.impact_ship), 0);
        chk("reset_wrap_x", int'(bB.posicion_x_attack), 2);

        // Cursor movement table, saturating (A) and wrapping (B).
        for (int v = 0; v < 14; v++) begin
            @(negedge clk) begin bA.en_attack = mv[v].en; set_btn(mv[v].btn); end
            @(negedge clk) begin set_btn(5'b0); bA.en_attack = 1'b1; end
            chk($sformatf("mv%0d_sat_x", v),  int'(bA.posicion_x_attack), mv[v].ax);
            chk($sformatf("mv%0d_sat_y", v),  int'(bA.posicion_y_attack), mv[v].ay);
            chk($sformatf("mv%0d_wrap_x", v), int'(bB.posicion_x_attack), mv[v].bx);
            chk($sformatf("mv%0d_wrap_y", v), int'(bB.posicion_y_attack), mv[v].by);
        end
        repeat (3) @(negedge clk);
        chk_board("move_with_attack_no_shot", bA.matriz_pc_final, '0);
        chk("move_with_attack_end", int'(bA.end_attack), 0);

        // Shot sequences.
        do_reset();
        bA.en_attack = 1'b1;
        shoot(2, 2, 1);            // water
        shoot(1, 1, 1);            // ship 2 hit
        // Re-firing on an already-shot cell does nothing.
        pulse(5'b00001);
        repeat (4) @(negedge clk);
        chk("reshot_end", int'(bA.end_attack), 0);
        chk("reshot_state", int'(dutA.r_state), 0);
        chk_board("reshot_board", bA.matriz_pc_final, pack_model());
        shoot(2, 3, 10);           // attack held for 10 clocks: one miss only
        shoot(1, 0, 1);            // sinks ship 2
        chk("hp2_zero", int'(dutA.r_hp[2]), 0);
        shoot(2, 0, 1);            // invalid ship id -> miss
        shoot(1, 4, 1);            // ship 1
        for (int x = 0; x < 3; x++) shoot(3, x, 1);
        for (int x = 0; x < 4; x++) shoot(4, x, 1);
        for (int x = 0; x < 5; x++) shoot(0, x, 1);
        chk("fleet_sunk", int'(bA.all_sunk), 1);

        // Reset arriving partway through a sweep.
        do_reset();
        bA.en_attack = 1'b1;
        goto(1, 4);
        pulse(5'b00001);
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            @(posedge clk);
            #1;
            if (int'(dutA.r_state) == 2 && int'(dutA.r_sweep_idx) == 10) reached = 1'b1;
        end
        chk("sweep_idx10_reached", int'(reached), 1);
        chk("sweep_partial_mark", int'(bA.matriz_pc_final[9*4 +: 4]), 8);
        rst = 1'b1;
        #1;
        chk_board("midsweep_reset_board", bA.matriz_pc_final, '0);
        chk("midsweep_reset_state", int'(dutA.r_state), 0);
        chk("midsweep_reset_hp1", int'(dutA.r_hp[1]), 1);
        chk("midsweep_reset_end", int'(bA.end_attack), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_reset_x", int'(bA.posicion_x_attack), 2);
        shoot(1, 4, 1);            // same shot now completes normally

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ataque_param.md
# ataque_param

Clocked, parametrised attack controller for the Battleship player turn. Moves an attack cursor over an N×N view of the opponent's board and resolves one shot per turn against the PC ship map. Tracks the hit points of each ship internally and, when a ship sinks, marks every cell of that ship as sunk in a multi-cycle sweep. Sits between the button debouncers and the turn FSM / VGA renderer; the turn FSM grants the turn with `en_attack` and waits for `end_attack`.

## Interface
- `N`, 5: board side length; N ≥ 2.
- `NUM_SHIPS`, 5: number of ships. Ship k (1..NUM_SHIPS) has length k.
- `WRAP`, 0: 1 = cursor wraps at board edges; 0 = cursor saturates at edges.
- `W`, $clog2(N): cursor coordinate width (derived).
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `izquierda`, `derecha`, `arriba`, `abajo`  in  1 each: debounced level buttons, synchronous to `clk`.
- `attack`  in  1: fire button, debounced level, synchronous to `clk`.
- `en_attack`  in  1: turn grant from the turn FSM.
- `matriz_pc`  in  4·N·N: PC ship map. Cell (y,x) is bits [4·(y·N+x) +: 4]. 0 = water; k = ship k.
- `matriz_pc_final`  out  4·N·N: shot board, same layout. 0 = unknown, 6 = miss, 7 = hit, 8 = sunk.
- `end_attack`  out  1: shot resolved; held high until `en_attack` falls.
- `impact_ship`  out  3: ship id hit by the last shot; 0 = miss.
- `posicion_x_attack`, `posicion_y_attack`  out  W each: cursor position.
- `all_sunk`  out  1: high when every ship's HP is 0.

## Operation
- Rising edges are detected on all five buttons using registered previous values. Only one action is taken per cycle, with priority `izquierda` > `derecha` > `arriba` > `abajo` > `attack`.
- Moves (state IDLE and `en_attack`=1 only):
  - `izquierda` increments x; `derecha` decrements x.
  - `arriba` increments y; `abajo` decrements y.
  - At an edge (x or y at N-1 going up, or 0 going down): with WRAP=0 the move is ignored; with WRAP=1 the coordinate wraps to 0 / N-1.
- HP registers: `hp[k]`, width 3, reset value k.
- States:
  - IDLE: accepts moves. An attack edge on a cell whose shot board value is 0 latches the cursor and goes to RESOLVE. An attack edge on a cell already shot is ignored (stays in IDLE).
  - RESOLVE (1 cycle): reads ship id s at the cursor.
    - s = 0 or s > NUM_SHIPS: write 6, `impact_ship`=0, go to DONE.
    - Otherwise: `impact_ship`=s and `hp[s]` decrements. If the new HP is 0, go to SWEEP; else write 7 and go to DONE.
  - SWEEP (N·N cycles): index i = 0..N·N-1, one cell per cycle. Writes 8 wherever `matriz_pc` equals s. Other cells are untouched. After the last index, go to DONE.
  - DONE: `end_attack`=1. When `en_attack`=0: go to IDLE, clear `end_attack`, and recentre the cursor to (N/2, N/2) using integer division.
- Dropping `en_attack` during RESOLVE or SWEEP does not abort; the shot completes and DONE then exits on the next cycle.
- Button edges arriving outside IDLE are discarded; the edge registers still update.
- `all_sunk` is combinational from the HP registers.

## Timing
- Reset values (asynchronous):
  - Shot board: all 0.
  - Cursor: (N/2, N/2).
  - `end_attack`=0, `impact_ship`=0, `all_sunk`=0.
  - `hp[k]`=k, edge registers 0, state IDLE.
- Cursor move: visible on the output one clock after the edge is sampled.
- Shot latency (edge sampled at clock 0):
  - Miss or non-sinking hit: cell written at clock 1; `end_attack` high after clock 2.
  - Sinking hit: `end_attack` high after clock 2+N·N. The cell is written 8, never 7.
- `impact_ship` updates at the RESOLVE clock and holds until the next RESOLVE or reset.
- Reset asserted mid-SWEEP: board cleared immediately; no partial marks remain.

## Test plan
- Reset, N=5: cursor (2,2), board all 0, `end_attack`=0, `all_sunk`=0. Three `izquierda` pulses with WRAP=0 → x=4; with WRAP=1 → x=0.
- Water at (2,2), `en_attack`=1, attack pulse → cell (2,2)=6, `impact_ship`=0, `end_attack` high 2 clocks after the edge. Drop `en_attack` → `end_attack`=0, cursor (2,2).
- Ship 2 at (1,0),(1,1): hit (1,1) → cell=7, `impact_ship`=2. Next turn hit (1,0) → both cells = 8 after 2+25 clocks; `hp[2]`=0.
- Hold `attack` high for 10 cycles → exactly one shot. Attack on an already-shot cell → no state change; `end_attack` stays 0.
- Sink all 5 ships (15 hits) → `all_sunk`=1. Pulse `izquierda` and `attack` in the same cycle → only the move happens.
- Assert `reset` at SWEEP index 10 → board all 0, state IDLE, HP restored; the next shot resolves normally.
